// File: rtl/div8_seq.sv
// div8_seq: iterative restoring unsigned divider, one trial subtraction per clock.
module div8_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_q, r_r, r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_shift, w_q_nx, w_r_nx;
  logic [WIDTH:0]   w_trial;
  // Partial remainder before iteration i is below 2^i, so dropping R's MSB never loses a bit.
  assign w_shift = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_trial = {1'b0, w_shift} - {1'b0, r_d};
  assign w_r_nx  = w_trial[WIDTH] ? w_shift : w_trial[WIDTH-1:0];
  assign w_q_nx  = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_q       <= '0;
      r_r       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else if (r_state == RUN) begin
      r_q   <= w_q_nx;
      r_r   <= w_r_nx;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_state   <= DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
        quotient  <= w_q_nx;
        remainder <= w_r_nx;
      end
    end else begin
      done <= start && divisor == '0;
      if (!start) r_state <= IDLE;
      else if (divisor == '0) begin
        r_state   <= DONE;
        r_d       <= divisor;
        quotient  <= '1;
        remainder <= dividend;
        divByZero <= 1'b1;
      end else begin
        r_state   <= RUN;
        r_d       <= divisor;
        r_q       <= dividend;
        r_r       <= '0;
        r_cnt     <= '0;
        busy      <= 1'b1;
        divByZero <= 1'b0;
      end
    end
endmodule

// File: tb/tb_div8_seq.sv
// tb_div8_seq: directed and random checks of div8_seq against an arithmetic reference.
module tb_div8_seq;
  logic       clk = 0;
  logic       rst = 0;
  logic       start = 0;
  logic [7:0] dividend = 0, divisor = 0;
  logic       busy, done, divByZero;
  logic [7:0] quotient, remainder;
  int checks = 0, errors = 0;
  int m_busy = 0, m_done = 0, m_q = 0, m_r = 0, m_dbz = 0, m_left = 0, m_d = 0, m_v = 0;

  div8_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a countdown of WIDTH edges, result from plain / and %.
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_q <= 0; m_r <= 0; m_dbz <= 0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= int'(m_left == 1);
      if (m_left == 1) begin
        m_busy <= 0;
        m_q    <= m_d / m_v;
        m_r    <= m_d % m_v;
      end
    end else begin
      m_done <= 0;
      if (start) begin
        m_d <= int'(dividend);
        m_v <= int'(divisor);
        if (divisor == 0) begin
          m_q <= 255; m_r <= int'(dividend); m_dbz <= 1; m_done <= 1;
        end else begin
          m_left <= 8; m_busy <= 1; m_dbz <= 0;
        end
      end
    end

  always @(negedge clk)
    if (!rst) begin
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      chk("quotient", int'(quotient), m_q);
      chk("remainder", int'(remainder), m_r);
      chk("divByZero", int'(divByZero), m_dbz);
      if (done && !divByZero && m_v != 0) begin
        chk("invariant_sum", int'(quotient) * m_v + int'(remainder), m_d);
        chk("invariant_rem_lt", int'(int'(remainder) < m_v), 1);
      end
    end

  task automatic go(input int d, input int v);
    start = 1;
    dividend = 8'(d);
    divisor = 8'(v);
  endtask

  task automatic finish_op(input string nm, input int eq, input int er, input int edz,
                           input int elat, input int ebusy, input int poke);
    int k = 0, nb = 0;
    @(negedge clk);
    start = 0;
    if (busy) nb++;
    while (!done && k < 20) begin
      if (k == poke) begin start = 1; dividend = 50; divisor = 5; end
      @(negedge clk);
      k++;
      if (k == poke + 1) start = 0;
      if (busy) nb++;
    end
    chk({nm, "_latency"}, k, elat);
    chk({nm, "_busy_cycles"}, nb, ebusy);
    chk({nm, "_q"}, int'(quotient), eq);
    chk({nm, "_r"}, int'(remainder), er);
    chk({nm, "_dbz"}, int'(divByZero), edz);
  endtask

  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_dbz", int'(divByZero), 0);
    rst = 0;
    @(negedge clk);
    go(100, 7);   finish_op("d100_7", 14, 2, 0, 8, 8, -1);
    @(negedge clk);
    chk("done_single_pulse", int'(done), 0);
    chk("hold_q_idle", int'(quotient), 14);
    go(255, 1);   finish_op("d255_1", 255, 0, 0, 8, 8, -1);
    go(5, 9);     finish_op("d5_9", 0, 5, 0, 8, 8, -1);
    go(128, 128); finish_op("d128_128", 1, 0, 0, 8, 8, -1);
    go(255, 255); finish_op("d255_255", 1, 0, 0, 8, 8, -1);
    go(0, 3);     finish_op("d0_3", 0, 0, 0, 8, 8, -1);
    @(negedge clk);
    go(200, 0);   finish_op("d200_0", 255, 200, 1, 0, 0, -1);
    @(negedge clk);
    go(100, 7);   finish_op("ignored_start", 14, 2, 0, 8, 8, 2);
    @(negedge clk);
    go(100, 7);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_q", int'(quotient), 0);
    chk("async_r", int'(remainder), 0);
    chk("async_dbz", int'(divByZero), 0);
    repeat (6) begin
      @(negedge clk);
      chk("aborted_no_done", int'(done), 0);
    end
    rst = 0;
    go(81, 9);    finish_op("d81_9", 9, 0, 0, 8, 8, -1);
    for (int i = 0; i < 2000; i++) begin
      int d, v;
      d = $urandom_range(0, 255);
      v = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
      go(d, v);
      finish_op("random", v != 0 ? d / v : 255, v != 0 ? d % v : d, int'(v == 0),
                v != 0 ? 8 : 0, v != 0 ? 8 : 0, -1);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
